trace_checker: RTL and testbench

TRACE_CHECKER -- requirements
Module: trace_checker

---
 rtl/trace_checker.sv | 193 +++++++++++++++++++
 tb/tb_trace_checker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_checker.sv
// Streaming checker for ASCII CPU trace records: parses one character per clock,
// validates time/PC/address/register fields and pulses a one-cycle verdict on '#'.
module trace_checker #(
    parameter int          TIME_DIGITS = 4,
    parameter int          GRF_DIGITS  = 4,
    parameter int          NUM_GRF     = 32,
    parameter logic [31:0] PC_LO       = 32'h3000,
    parameter logic [31:0] PC_HI       = 32'h4FFF,
    parameter logic [31:0] ADDR_LO     = 32'h0,
    parameter logic [31:0] ADDR_HI     = 32'h2FFF,
    parameter int          FREQ_W      = 16,
    parameter int          CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        char,
    input  logic [FREQ_W-1:0] freq,
    output logic [1:0]        format_type,
    output logic [3:0]        error_code,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_TIME     = 4'd1;
    localparam logic [3:0] S_PC       = 4'd2;
    localparam logic [3:0] S_COLON_SP = 4'd3;
    localparam logic [3:0] S_GRF      = 4'd4;
    localparam logic [3:0] S_ADDR     = 4'd5;
    localparam logic [3:0] S_PRE_LT   = 4'd6;
    localparam logic [3:0] S_EQ       = 4'd7;
    localparam logic [3:0] S_POST_EQ  = 4'd8;
    localparam logic [3:0] S_DATA     = 4'd9;
    localparam logic [3:0] S_END      = 4'd10;

    localparam logic [7:0] C_CARET  = 8'h5E;
    localparam logic [7:0] C_AT     = 8'h40;
    localparam logic [7:0] C_COLON  = 8'h3A;
    localparam logic [7:0] C_SPACE  = 8'h20;
    localparam logic [7:0] C_DOLLAR = 8'h24;
    localparam logic [7:0] C_STAR   = 8'h2A;
    localparam logic [7:0] C_LT     = 8'h3C;
    localparam logic [7:0] C_EQ     = 8'h3D;
    localparam logic [7:0] C_HASH   = 8'h23;

    logic [3:0]        state;
    logic [3:0]        dcnt;
    logic [31:0]       time_acc;
    logic [31:0]       pc_acc;
    logic [31:0]       addr_acc;
    logic [15:0]       grf_acc;
    logic              is_mem;
    logic [FREQ_W-1:0] freq_l;

    logic       is_dec;
    logic       hex_ok;
    logic [3:0] hex_val;
    logic [3:0] dec_val;

    always_comb begin
        is_dec  = (char >= 8'h30) && (char <= 8'h39);
        dec_val = char[3:0];
        hex_ok  = 1'b1;
        hex_val = 4'd0;
        if (is_dec)
            hex_val = char[3:0];
        else if ((char >= 8'h61 && char <= 8'h66) || (char >= 8'h41 && char <= 8'h46))
            hex_val = char[3:0] + 4'd9;
        else
            hex_ok = 1'b0;
    end

    // Verdict is formed from the accumulated fields; divisor forced nonzero so the
    // modulo is defined when freq < 2 (that case is flagged separately).
    logic [31:0] half;
    logic [31:0] half_safe;
    logic        t_err, pc_err, addr_err, grf_err;
    logic [3:0]  err;
    logic        done;

    always_comb begin
        half      = 32'(freq_l >> 1);
        half_safe = (half == 32'd0) ? 32'd1 : half;
        t_err     = (freq_l < FREQ_W'(2)) || ((time_acc % half_safe) != 32'd0);
        pc_err    = (pc_acc < PC_LO) || (pc_acc > PC_HI) || (pc_acc[1:0] != 2'b00);
        addr_err  = is_mem && ((addr_acc < ADDR_LO) || (addr_acc > ADDR_HI) || (addr_acc[1:0] != 2'b00));
        grf_err   = !is_mem && ({16'b0, grf_acc} >= 32'(NUM_GRF));
        err       = {grf_err, addr_err, pc_err, t_err};
        done      = (state == S_END) && (char == C_HASH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            dcnt     <= 4'd0;
            time_acc <= 32'd0;
            pc_acc   <= 32'd0;
            addr_acc <= 32'd0;
            grf_acc  <= 16'd0;
            is_mem   <= 1'b0;
            freq_l   <= '0;
        end else if (char == C_CARET) begin
            state    <= S_TIME;
            dcnt     <= 4'd0;
            time_acc <= 32'd0;
            pc_acc   <= 32'd0;
            addr_acc <= 32'd0;
            grf_acc  <= 16'd0;
            is_mem   <= 1'b0;
            freq_l   <= freq;
        end else begin
            case (state)
                S_TIME:
                    if (is_dec && dcnt < 4'(TIME_DIGITS)) begin
                        time_acc <= time_acc * 32'd10 + {28'b0, dec_val};
                        dcnt     <= dcnt + 4'd1;
                    end else if (char == C_AT && dcnt != 4'd0) begin
                        state <= S_PC;
                        dcnt  <= 4'd0;
                    end else state <= S_IDLE;
                S_PC:
                    if (hex_ok && dcnt < 4'd8) begin
                        pc_acc <= {pc_acc[27:0], hex_val};
                        dcnt   <= dcnt + 4'd1;
                    end else if (char == C_COLON && dcnt == 4'd8) state <= S_COLON_SP;
                    else state <= S_IDLE;
                S_COLON_SP:
                    if (char == C_DOLLAR) begin
                        state  <= S_GRF;
                        dcnt   <= 4'd0;
                        is_mem <= 1'b0;
                    end else if (char == C_STAR) begin
                        state  <= S_ADDR;
                        dcnt   <= 4'd0;
                        is_mem <= 1'b1;
                    end else if (char != C_SPACE) state <= S_IDLE;
                S_GRF:
                    if (is_dec && dcnt < 4'(GRF_DIGITS)) begin
                        grf_acc <= grf_acc * 16'd10 + {12'b0, dec_val};
                        dcnt    <= dcnt + 4'd1;
                    end else if (char == C_SPACE && dcnt != 4'd0) state <= S_PRE_LT;
                    else if (char == C_LT && dcnt != 4'd0) state <= S_EQ;
                    else state <= S_IDLE;
                S_ADDR:
                    if (hex_ok && dcnt < 4'd8) begin
                        addr_acc <= {addr_acc[27:0], hex_val};
                        dcnt     <= dcnt + 4'd1;
                    end else if (char == C_SPACE && dcnt == 4'd8) state <= S_PRE_LT;
                    else if (char == C_LT && dcnt == 4'd8) state <= S_EQ;
                    else state <= S_IDLE;
                S_PRE_LT:
                    if (char == C_LT) state <= S_EQ;
                    else if (char != C_SPACE) state <= S_IDLE;
                S_EQ:
                    state <= (char == C_EQ) ? S_POST_EQ : S_IDLE;
                S_POST_EQ:
                    if (hex_ok) begin
                        state <= S_DATA;
                        dcnt  <= 4'd1;
                    end else if (char != C_SPACE) state <= S_IDLE;
                // Data value is not checked, only its digit count.
                S_DATA:
                    if (hex_ok) begin
                        if (dcnt == 4'd7) state <= S_END;
                        else dcnt <= dcnt + 4'd1;
                    end else state <= S_IDLE;
                default:
                    state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            format_type <= 2'd0;
            error_code  <= 4'd0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
        end else if (done) begin
            format_type <= is_mem ? 2'd2 : 2'd1;
            error_code  <= err;
            if (err == 4'd0) begin
                if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
                if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
            end
        end else begin
            format_type <= 2'd0;
            error_code  <= 4'd0;
        end
    end

endmodule

// File: tb/tb_trace_checker.sv
// Randomized bench for trace_checker: a string-level parser of each '^'..'#' record
// predicts the verdict pulse and counters, with directed cases up front.
module tb_trace_checker;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    char;
    logic [FW-1:0] freq;
    logic [1:0]    ft, ft2;
    logic [3:0]    ec, ec2;
    logic [7:0]    pcnt, fcnt;
    logic [1:0]    pcnt2, fcnt2;

    always #5 clk = ~clk;

    trace_checker dut (
        .clk(clk), .reset(reset), .char(char), .freq(freq),
        .format_type(ft), .error_code(ec), .pass_cnt(pcnt), .fail_cnt(fcnt)
    );

    trace_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .char(char), .freq(freq),
        .format_type(ft2), .error_code(ec2), .pass_cnt(pcnt2), .fail_cnt(fcnt2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // reference model state
    string buff;
    bit    open   = 0;
    int    flat   = 0;
    int    m_pass = 0, m_fail = 0, m_pass2 = 0, m_fail2 = 0;
    bit    jitter = 0;

    function automatic logic [7:0] at(input string s, input int i);
        if (i < 0 || i >= s.len()) return 8'h00;
        return s[i];
    endfunction

    function automatic bit isdig(input logic [7:0] c);
        return c >= "0" && c <= "9";
    endfunction

    function automatic int hexv(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return -1;
    endfunction

    // Returns 1 when s is exactly one well-formed record; computes its verdict.
    function automatic bit parse(input string s, input int f, output int ftype, output int err);
        int i, n, half;
        longint t, pcv, addr, grf;
        ftype = 0; err = 0; addr = 0; grf = 0;
        if (at(s, 0) != "^") return 0;
        i = 1; n = 0; t = 0;
        while (isdig(at(s, i))) begin t = t * 10 + (int'(at(s, i)) - 48); n++; i++; end
        if (n < 1 || n > 4) return 0;
        if (at(s, i) != "@") return 0;
        i++; pcv = 0;
        for (int k = 0; k < 8; k++) begin
            if (hexv(at(s, i)) < 0) return 0;
            pcv = pcv * 16 + hexv(at(s, i)); i++;
        end
        if (at(s, i) != ":") return 0;
        i++;
        while (at(s, i) == " ") i++;
        if (at(s, i) == "$") begin
            i++; n = 0;
            while (isdig(at(s, i))) begin grf = grf * 10 + (int'(at(s, i)) - 48); n++; i++; end
            if (n < 1 || n > 4) return 0;
            ftype = 1;
        end else if (at(s, i) == "*") begin
            i++;
            for (int k = 0; k < 8; k++) begin
                if (hexv(at(s, i)) < 0) return 0;
                addr = addr * 16 + hexv(at(s, i)); i++;
            end
            ftype = 2;
        end else return 0;
        while (at(s, i) == " ") i++;
        if (at(s, i) != "<") return 0;
        i++;
        if (at(s, i) != "=") return 0;
        i++;
        while (at(s, i) == " ") i++;
        for (int k = 0; k < 8; k++) begin
            if (hexv(at(s, i)) < 0) return 0;
            i++;
        end
        if (at(s, i) != "#" || i + 1 != s.len()) return 0;
        half = f / 2;
        if (f < 2) err |= 1;
        else if (t % half != 0) err |= 1;
        if (pcv < 'h3000 || pcv > 'h4FFF || pcv % 4 != 0) err |= 2;
        if (ftype == 2 && (addr > 'h2FFF || addr % 4 != 0)) err |= 4;
        if (ftype == 1 && grf >= 32) err |= 8;
        return 1;
    endfunction

    task automatic step(input logic [7:0] c);
        int eft = 0, eec = 0, ty, er;
        @(negedge clk);
        if (jitter && c != "^" && $urandom_range(0, 19) == 0) freq = FW'($urandom_range(0, 100));
        char = c;
        if (c == "^") begin
            buff = "^"; open = 1; flat = int'(freq);
        end else if (open) begin
            buff = $sformatf("%s%c", buff, c);
            if (c == "#") begin
                open = 0;
                if (parse(buff, flat, ty, er)) begin
                    eft = ty; eec = er;
                    if (er == 0) begin
                        if (m_pass < 255) m_pass++;
                        if (m_pass2 < 3) m_pass2++;
                    end else begin
                        if (m_fail < 255) m_fail++;
                        if (m_fail2 < 3) m_fail2++;
                    end
                end
            end
        end
        @(posedge clk); #1;
        chk("format_type", ft, eft);
        chk("error_code", ec, eec);
        chk("pass_cnt", pcnt, m_pass);
        chk("fail_cnt", fcnt, m_fail);
        chk("pass_cnt_w2", pcnt2, m_pass2);
        chk("fail_cnt_w2", fcnt2, m_fail2);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(s[i]);
    endtask

    function automatic string hexs(input logic [31:0] v);
        string r = "";
        bit up = $urandom_range(0, 3) == 0;
        int nib;
        for (int k = 7; k >= 0; k--) begin
            nib = int'(v[4*k +: 4]);
            r = $sformatf("%s%c", r, nib < 10 ? 48 + nib : (up ? 55 : 87) + nib);
        end
        return r;
    endfunction

    function automatic string sp();
        string r = "";
        int n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) r = {r, " "};
        return r;
    endfunction

    task automatic rand_rec();
        string s, ts, noise;
        int f, half, t, idx;
        logic [31:0] v;
        logic [31:0] pcb [7];
        logic [31:0] adb [5];
        pcb = '{32'h3000, 32'h4FFC, 32'h4FFD, 32'h4FFF, 32'h5000, 32'h2FFC, 32'h3002};
        adb = '{32'h0, 32'h2FFC, 32'h2FFD, 32'h3000, 32'h2FFF};
        noise = "g:@ $*x9A#<=";
        case ($urandom_range(0, 7))
            0: f = 0;  1: f = 1;  2: f = 2;  3: f = 4;
            4: f = 8;  5: f = 16; 6: f = 32;
            default: f = $urandom_range(0, 200);
        endcase
        freq = FW'(f);
        half = f / 2;
        if (half > 0 && $urandom_range(0, 1) == 1) t = half * $urandom_range(0, 9999 / half);
        else t = $urandom_range(0, 9999);
        ts = $sformatf("%0d", t);
        if ($urandom_range(0, 9) == 0) ts = {"0", ts};
        if ($urandom_range(0, 19) == 0) ts = "";
        case ($urandom_range(0, 2))
            0: v = 32'h3000 + 4 * $urandom_range(0, 'h7FF);
            1: v = $urandom;
            default: v = pcb[$urandom_range(0, 6)];
        endcase
        s = {"^", ts, "@", hexs(v), ":", sp()};
        if ($urandom_range(0, 1) == 1) begin
            s = {s, "$", $sformatf("%0d", $urandom_range(0, 40))};
        end else begin
            case ($urandom_range(0, 2))
                0: v = 4 * $urandom_range(0, 'hBFF);
                1: v = $urandom;
                default: v = adb[$urandom_range(0, 4)];
            endcase
            s = {s, "*", hexs(v)};
        end
        s = {s, sp(), "<=", sp(), hexs($urandom), "#"};
        if ($urandom_range(0, 99) < 15) begin
            idx = $urandom_range(1, s.len() - 1);
            s.putc(idx, noise[$urandom_range(0, noise.len() - 1)]);
        end
        if ($urandom_range(0, 9) == 0) s = s.substr(0, s.len() - 2);
        send_str(s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; char = 8'h00; freq = 16'd32;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ft", ft, 0);
        chk("rst_ec", ec, 0);
        chk("rst_pass", pcnt, 0);
        chk("rst_fail", fcnt, 0);
        @(negedge clk); reset = 1'b1;

        freq = 16'd32;
        send_str("^16@00003004: $5 <= 0000000a#");
        chk("r31_ft", ft, 1); chk("r31_ec", ec, 0); chk("r31_pass", pcnt, 1);
        send_str("^5@00003333: *00000300 <= fffffb28#");
        chk("r32_ft", ft, 2); chk("r32_ec", ec, 4'b0011); chk("r32_fail", fcnt, 1);
        freq = 16'd16;
        send_str("^8@00003000:$40<=00000000#");
        chk("r33_ft", ft, 1); chk("r33_ec", ec, 4'b1000);
        freq = 16'd2;
        send_str("^12@0000300g: $1 <= 00000001#");
        chk("r34_bad_ft", ft, 0);
        send_str("^3@00003000: $1 <= 00000001#");
        chk("r34_ft", ft, 1); chk("r34_ec", ec, 0);
        // back-to-back records and digit-count boundaries
        send_str("^9999@00004FFC: *00002FFC<=ABCDEF01#^10@00003000: $0031 <= 00000000#");
        send_str("^12345@00003000: $1 <= 00000001#^2@00003000: $00001 <= 00000001#");

        freq = 16'd32;
        send_str("^4@00003");
        #2; reset = 1'b0; #1;
        chk("r35_ft", ft, 0); chk("r35_ec", ec, 0);
        chk("r35_pass", pcnt, 0); chk("r35_fail", fcnt, 0);
        open = 0; m_pass = 0; m_fail = 0; m_pass2 = 0; m_fail2 = 0;
        @(negedge clk); reset = 1'b1;
        send_str("000: $1 <= 00000001#");
        chk("r35_after_ft", ft, 0);

        freq = 16'd0;
        send_str("^0@00003000: $0 <= 00000000#");
        chk("r36_ec", ec, 4'b0001);
        freq = 16'd32;
        for (int k = 0; k < 5; k++) send_str("^16@00003004: $5 <= 0000000a#");
        chk("r36_pass8", pcnt, 5);
        chk("r36_sat2", pcnt2, 3);

        jitter = 1;
        for (int r = 0; r < 300; r++) begin
            if ($urandom_range(0, 9) == 0) send_str("x# ");
            rand_rec();
        end
        jitter = 0;
        step(" ");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
